// File: rtl/modular_exponentiator_pkg.sv
// Shared types and constants for the modular exponentiator.
// Holds the controller state encoding and the default operand width.
package modexp_pkg;

  localparam int N = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_REQ,
    MUL_WAIT,
    SHIFT,
    SQR_REQ,
    SQR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/modular_exponentiator.sv
// Right-to-left square-and-multiply controller computing R = B^E mod M using an external multiplier.
// Optional MODEXP_CYCLE_COUNT_EN adds a saturating busy-cycle counter output 'cycles'.
module modular_exponentiator
  import modexp_pkg::*;
#(
  parameter int n = N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] B,
  input  logic [n-1:0] E,
  input  logic [n-1:0] M,
  output logic [n-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [n-1:0] mult_X,
  output logic [n-1:0] mult_Y,
  output logic [n-1:0] mult_M,
  output logic         mult_start,
  input  logic         mult_done,
  input  logic [n-1:0] mult_P
`ifdef MODEXP_CYCLE_COUNT_EN
  ,
  output logic [15:0]  cycles
`endif
);

  localparam logic [n-1:0] ONE = n'(1);

  state_t       r_state;
  state_t       w_nextState;
  logic [n-1:0] r_b;
  logic [n-1:0] r_e;
  logic [n-1:0] r_m;
  logic [n-1:0] r_acc;
  logic [n-1:0] r_result;
  logic         r_err;
  logic         w_trivial;

  // Degenerate moduli and a zero exponent finish straight from CHECK without the multiplier.
  assign w_trivial = (r_m == '0) || (r_b >= r_m) || (r_m == ONE) || (r_e == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (start) w_nextState = CHECK;
      CHECK:    w_nextState = w_trivial ? DONE : (r_e[0] ? MUL_REQ : SHIFT);
      MUL_REQ:  w_nextState = MUL_WAIT;
      MUL_WAIT: if (mult_done) w_nextState = SHIFT;
      SHIFT:    w_nextState = (r_e[n-1:1] == '0) ? DONE : SQR_REQ;
      SQR_REQ:  w_nextState = SQR_WAIT;
      SQR_WAIT: if (mult_done) w_nextState = r_e[0] ? MUL_REQ : SHIFT;
      DONE:     w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Operands are decoded from state so they stay stable for the whole request/wait window.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mult_start = 1'b0;
    mult_X     = '0;
    mult_Y     = '0;
    mult_M     = '0;
    case (r_state)
      CHECK, SHIFT: busy = 1'b1;
      MUL_REQ, MUL_WAIT: begin
        busy       = 1'b1;
        mult_start = (r_state == MUL_REQ);
        mult_X     = r_acc;
        mult_Y     = r_b;
        mult_M     = r_m;
      end
      SQR_REQ, SQR_WAIT: begin
        busy       = 1'b1;
        mult_start = (r_state == SQR_REQ);
        mult_X     = r_b;
        mult_Y     = r_b;
        mult_M     = r_m;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_b      <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_b   <= B;
            r_e   <= E;
            r_m   <= M;
            r_acc <= ONE;
            r_err <= 1'b0;
          end
        end
        CHECK: begin
          if ((r_m == '0) || (r_b >= r_m)) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else if (r_m == ONE) begin
            r_result <= '0;
          end else if (r_e == '0) begin
            r_result <= ONE;
          end
        end
        MUL_WAIT: if (mult_done) r_acc <= mult_P;
        SHIFT: begin
          r_e <= r_e >> 1;
          if (r_e[n-1:1] == '0) r_result <= r_acc;
        end
        SQR_WAIT: if (mult_done) r_b <= mult_P;
        default: ;
      endcase
    end
  end

  assign R   = r_result;
  assign err = r_err;

`ifdef MODEXP_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  always_ff @(posedge clk) begin
    if (reset)                             r_cycles <= '0;
    else if ((r_state == IDLE) && start)   r_cycles <= '0;
    else if (busy && (r_cycles != 16'hFFFF)) r_cycles <= r_cycles + 16'd1;
  end

  assign cycles = r_cycles;
`endif

endmodule
